// File: rtl/mips_cpu_bus_mem_ctrl_if.sv
// Core request/response and Avalon-style memory bus signals of the memory-access controller.
interface mips_cpu_bus_mem_ctrl_if;
  logic        req;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  req, req_write, req_addr, req_size, req_signed, req_wdata,
    input  waitrequest, readdata,
    output busy, done, err, rdata,
    output address, write, read, writedata, byteenable
  );

  modport slave (
    output req, req_write, req_addr, req_size, req_signed, req_wdata,
    output waitrequest, readdata,
    input  busy, done, err, rdata,
    input  address, write, read, writedata, byteenable
  );
endinterface

// File: rtl/mips_cpu_bus_mem_ctrl.sv
// Memory-access controller: one byte/half/word request at a time onto an Avalon-style bus,
// with lane placement for stores and lane extraction plus sign/zero extension for loads.
module mips_cpu_bus_mem_ctrl (
  input  logic                          clk,
  input  logic                          reset,
  mips_cpu_bus_mem_ctrl_if.master       bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] FAULT   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [1:0]  state, state_nxt;
  logic        busy, busy_nxt;
  logic        done, done_nxt;
  logic        err, err_nxt;
  logic        rd, rd_nxt;
  logic        wr, wr_nxt;
  logic [31:0] rdata, rdata_nxt;
  logic [31:0] address, address_nxt;
  logic [31:0] wdata, wdata_nxt;
  logic [3:0]  be, be_nxt;
  logic [1:0]  size_q, size_nxt;
  logic [1:0]  off_q, off_nxt;
  logic        sgn_q, sgn_nxt;

  logic        misaligned_c;
  logic [4:0]  req_shift_c;
  logic [31:0] req_wdata_c;
  logic [3:0]  req_be_c;
  logic [15:0] lane_c;
  logic [31:0] load_c;

  // Request decode: alignment, lane placement of store data and byte enables.
  always_comb begin
    req_shift_c  = {bus.req_addr[1:0], 3'b000};
    misaligned_c = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                   (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    case (bus.req_size)
      SZ_BYTE: begin
        req_wdata_c = 32'(bus.req_wdata[7:0]) << req_shift_c;
        req_be_c    = 4'b0001 << bus.req_addr[1:0];
      end
      SZ_HALF: begin
        req_wdata_c = 32'(bus.req_wdata[15:0]) << req_shift_c;
        req_be_c    = 4'b0011 << bus.req_addr[1:0];
      end
      default: begin
        req_wdata_c = bus.req_wdata;
        req_be_c    = 4'b1111;
      end
    endcase
  end

  // Load extraction from the registered offset/size.
  always_comb begin
    lane_c = 16'(bus.readdata >> {off_q, 3'b000});
    case (size_q)
      SZ_BYTE: load_c = {{24{sgn_q & lane_c[7]}}, lane_c[7:0]};
      SZ_HALF: load_c = {{16{sgn_q & lane_c[15]}}, lane_c[15:0]};
      default: load_c = bus.readdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd      <= 1'b0;
      wr      <= 1'b0;
      rdata   <= 32'h0;
      address <= 32'h0;
      wdata   <= 32'h0;
      be      <= 4'h0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      sgn_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      rd      <= rd_nxt;
      wr      <= wr_nxt;
      rdata   <= rdata_nxt;
      address <= address_nxt;
      wdata   <= wdata_nxt;
      be      <= be_nxt;
      size_q  <= size_nxt;
      off_q   <= off_nxt;
      sgn_q   <= sgn_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    rd_nxt      = 1'b0;
    wr_nxt      = 1'b0;
    rdata_nxt   = rdata;
    address_nxt = address;
    wdata_nxt   = wdata;
    be_nxt      = be;
    size_nxt    = size_q;
    off_nxt     = off_q;
    sgn_nxt     = sgn_q;

    case (state)
      IDLE: begin
        if (bus.req) begin
          busy_nxt = 1'b1;
          size_nxt = bus.req_size;
          off_nxt  = bus.req_addr[1:0];
          sgn_nxt  = bus.req_signed;
          if (misaligned_c) begin
            state_nxt = FAULT;
          end else begin
            state_nxt   = ACCESS;
            rd_nxt      = ~bus.req_write;
            wr_nxt      = bus.req_write;
            address_nxt = {bus.req_addr[31:2], 2'b00};
            wdata_nxt   = req_wdata_c;
            be_nxt      = req_be_c;
          end
        end
      end
      ACCESS: begin
        if (bus.waitrequest) begin
          busy_nxt = 1'b1;
          rd_nxt   = rd;
          wr_nxt   = wr;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          if (rd) rdata_nxt = load_c;
        end
      end
      FAULT: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        err_nxt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.rdata      = rdata;
  assign bus.address    = address;
  assign bus.read       = rd;
  assign bus.write      = wr;
  assign bus.writedata  = wdata;
  assign bus.byteenable = be;

endmodule

// File: doc/mips_cpu_bus_mem_ctrl.md
# mips_cpu_bus_mem_ctrl

Memory-access controller inside `mips_cpu_bus`, sitting between the CPU core's fetch/load-store logic and the external Avalon-style memory bus that `RAM_32x4096` serves. It accepts one byte, halfword or word request at a time from the core. It drives `address/read/write/writedata/byteenable`, holds them through `waitrequest` stalls, and returns load data lane-extracted and sign- or zero-extended. Misaligned requests are rejected without a bus cycle.

## Interface
- No parameters.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`
- `req`  in  1  core request strobe; sampled only while `busy`=0
- `req_write`  in  1  1 = store, 0 = load/fetch
- `req_addr`  in  32  byte address
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- `req_signed`  in  1  loads only: 1 sign-extend, 0 zero-extend
- `req_wdata`  in  32  store data, right-justified
- `busy`  out  1  request accepted and not yet completed
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  with `done`: request was misaligned, no bus access made
- `rdata`  out  32  extended load result, valid while `done`=1, held until next completion
- `address`  out  32  word-aligned bus address
- `write`  out  1  bus write strobe
- `read`  out  1  bus read strobe
- `waitrequest`  in  1  slave stall
- `writedata`  out  32  lane-placed store data
- `byteenable`  out  4  active lanes
- `readdata`  in  32  bus read data

## Operation
- The state machine has three states:
  - IDLE: `busy`=0. On `req`=1, register all request fields.
    - Aligned request: go to ACCESS.
    - Misaligned request (halfword with `addr[0]`=1, or word with `addr[1:0]`≠0): go to FAULT.
  - ACCESS: `busy`=1. Drive `read`=~`req_write` and `write`=`req_write` from registers.
    - On an edge with `waitrequest`=0: the transfer completes. Capture the load result, go to IDLE, and pulse `done`.
    - With `waitrequest`=1: stay in ACCESS, holding all bus outputs constant.
  - FAULT: `busy`=1. Go to IDLE next edge, pulse `done` and `err`, and leave `rdata` unchanged.
- Lane mapping is little-endian: byte offset k = `addr[1:0]` occupies bits [8k+7:8k].
- `address` = {`req_addr[31:2]`, 2'b00}.
- `byteenable` by size:
  - byte: 4'b0001 << k
  - half: 4'b0011 << k (k ∈ {0,2})
  - word: 4'b1111
- `writedata` = `req_wdata` shifted left 8k bits for byte/half, with non-enabled lanes zero.
- Load extraction takes the selected lane(s) from `readdata` and extends them to 32 bits per `req_signed`. For word loads `req_signed` is ignored.
- `req` while `busy`=1 is ignored. The core must re-present the request after `done`.
- Outside ACCESS: `read`=`write`=0; `address`, `writedata`, `byteenable` hold their last values.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rdata`=0, `read`=0, `write`=0, `address`=0, `writedata`=0, `byteenable`=0; state IDLE.
- Reset mid-ACCESS aborts: strobes drop at that edge and no `done` is issued. This aborts the bus handshake; the slave is reset together with the CPU.
- Request sampled at edge E0. Bus strobes are high from E0 to E1.
  - Zero wait states: completion at E1, `done` high for the cycle after E1. Request-to-`done` latency is 2 cycles.
  - Each `waitrequest`=1 cycle adds exactly one cycle.
- Misaligned: `done`=`err`=1 for the cycle after E1. `read`/`write` never assert.
- `done` and `err` are never high for two consecutive cycles.
- Back-to-back: a new `req` is accepted in the `done` cycle, since state is already IDLE. Minimum spacing is one request every 2 cycles.
- `readdata` is sampled only on the completing edge. Values during `waitrequest`=1 are ignored.

## Test plan
- Word load, zero wait: RAM word at 0xBFC00028 = 0xE3C863C7, request lw addr 0xBFC00028 → `read`=1, `byteenable`=1111, `address`=0xBFC00028 for one cycle; `done` 2 cycles after `req` with `rdata`=0xE3C863C7, `err`=0.
- Signed/unsigned byte: word 0x80FF7F01 at 0x100, lb addr 0x102 → `byteenable`=0100, `rdata`=0xFFFFFFFF; lbu same addr → 0x000000FF; lb addr 0x101 → 0x0000007F.
- Halfword store with stalls: sh addr 0x206 data 0x1234ABCD, `waitrequest` high 3 cycles → `write`, `address`=0x204, `byteenable`=1100, `writedata`=0xABCD0000 stable for 4 cycles; `done` 5 cycles after `req`; subsequent lw 0x204 returns 0xABCDxxxx (low half untouched).
- Misaligned: lw addr 0x101 and lh addr 0x103 → no `read`/`write` ever, `done`=`err`=1 one cycle, `rdata` unchanged.
- Busy ignore / back-to-back: second `req` asserted during ACCESS is dropped (exactly one bus transfer). A `req` in the `done` cycle is accepted, and the next transfer starts the following cycle.
- Reset mid-stall: assert `reset` during ACCESS with `waitrequest`=1 → next edge `read`=`write`=0, `busy`=0, no `done`; a fresh lw afterwards completes normally.
